if_fetch: RTL and testbench

//  Instruction-fetch stage with the IF/ID pipeline register folded in. Owns the PC.

---
 rtl/if_fetch_if.sv | 35 +++
 rtl/if_fetch.sv | 177 +++++++++++++++++
 tb/tb_if_fetch.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_fetch_if
// Instruction-memory request/response bundle between the fetch stage and the
// instruction memory. One request is accepted when req && gnt; the response
// arrives later as a one-cycle rvalid pulse carrying rdata.
//   req     fetch -> mem   request valid
//   addr    fetch -> mem   word-aligned fetch address
//   gnt     mem -> fetch   request accepted this cycle
//   rvalid  mem -> fetch   response valid
//   rdata   mem -> fetch   response instruction word
// ---------------------------------------------------------------------------
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage with the IF/ID pipeline register folded in. Owns the
// PC, keeps at most one instruction-memory request outstanding, and parks one
// response in a skid buffer while decode is stalled.
// Ports:
//   clk                      clock, all state on the rising edge
//   rst                      asynchronous, active-low reset
//   stall_i                  decode stalled: hold pc_o/inst_o/inst_valid_o
//   branch_flag_i            redirect fetch to branch_target_address_i
//   branch_target_address_i  redirect target (word aligned, used unmodified)
//   imem                     instruction-memory port (master side)
//   pc_o                     PC of inst_o
//   inst_o                   instruction to decode (NOP_INST when no valid inst)
//   inst_valid_o             inst_o is a real fetched instruction
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_address_i,
  if_fetch_if.master        imem,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  // Instruction handed to the output register this cycle (if any).
  logic        new_vld;
  logic [31:0] new_pc;
  logic [31:0] new_inst;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    new_vld    = 1'b0;
    new_pc     = buf_pc_q;
    new_inst   = buf_inst_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (branch_flag_i) fetch_pc_d = branch_target_address_i;
      end

      S_REQ: begin
        if (imem.gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
          // The old address is already in flight: its response must be
          // discarded when it shows up.
          if (branch_flag_i) begin
            kill_d     = 1'b1;
            fetch_pc_d = branch_target_address_i;
          end
        end else if (branch_flag_i) begin
          // Not yet accepted, so the request can simply be retargeted.
          fetch_pc_d = branch_target_address_i;
        end
      end

      S_WAIT: begin
        if (branch_flag_i) fetch_pc_d = branch_target_address_i;
        if (imem.rvalid) begin
          state_d = S_REQ;
          if (kill_q || branch_flag_i) begin
            kill_d = 1'b0;
          end else if (!stall_i) begin
            new_vld  = 1'b1;
            new_pc   = req_pc_q;
            new_inst = imem.rdata;
          end else begin
            buf_pc_d   = req_pc_q;
            buf_inst_d = imem.rdata;
            state_d    = S_FULL;
          end
        end else if (branch_flag_i) begin
          kill_d = 1'b1;
        end
      end

      S_FULL: begin
        if (branch_flag_i) begin
          fetch_pc_d = branch_target_address_i;
          state_d    = S_REQ;
        end else if (!stall_i) begin
          new_vld = 1'b1;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Output register: a branch flushes even a stalled decode slot; pc is
    // only ever replaced by a newly delivered instruction.
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (branch_flag_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (new_vld) begin
        pc_d    = new_pc;
        inst_d  = new_inst;
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      kill_q     <= 1'b0;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= NOP_INST;
      pc_q       <= 32'h0;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign imem.req     = req_q;
  assign imem.addr    = fetch_pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
// Bench for if_fetch: a memory model grants requests and answers with a
// configurable delay; expected request addresses and delivered (pc, inst)
// pairs are queued by the stimulus and checked as the DUT produces them.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;

  if_fetch_if imem();

  if_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall),
    .branch_flag_i           (branch),
    .branch_target_address_i (target),
    .imem                    (imem),
    .pc_o                    (pc),
    .inst_o                  (inst),
    .inst_valid_o            (valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_req[$];
  logic [63:0] exp_out[$];

  int          grants_left = 0;
  int          rv_delay    = 1;
  logic        pend        = 1'b0;
  int          pend_cnt    = 0;
  logic [31:0] pend_addr   = 32'h0;
  logic [31:0] req_e;
  logic [63:0] out_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00A0_0093 : a;
  endfunction

  // Memory model: drives its outputs on the falling edge.
  always @(negedge clk) begin
    imem.rvalid = 1'b0;
    imem.gnt    = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_data(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem.req === 1'b1 && grants_left > 0) begin
      imem.gnt    = 1'b1;
      grants_left--;
      pend        = 1'b1;
      pend_cnt    = rv_delay;
      pend_addr   = imem.addr;
      chk("req_expected", 32'(exp_req.size() != 0), 32'd1);
      if (exp_req.size() != 0) begin
        req_e = exp_req.pop_front();
        chk("req_addr", imem.addr, req_e);
      end
    end
  end

  // Decode-side monitor: an instruction is consumed when valid and not stalled.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1 && !stall && !branch) begin
      chk("out_expected", 32'(exp_out.size() != 0), 32'd1);
      if (exp_out.size() != 0) begin
        out_e = exp_out.pop_front();
        chk("out_pc", pc, out_e[63:32]);
        chk("out_inst", inst, out_e[31:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (valid !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_out.size() != 0 || exp_req.size() != 0) && k < 40) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(exp_out.size() + exp_req.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0;
    cyc(3);
    chk("rst_req",   32'(imem.req), 32'd0);
    chk("rst_addr",  imem.addr, 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_inst",  inst, NOP);
    chk("rst_valid", 32'(valid), 32'd0);

    // 1: streaming fetch, inst = address
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_out.push_back({32'h0, 32'h0}); exp_out.push_back({32'h4, 32'h4});
    exp_out.push_back({32'h8, 32'h8});
    grants_left = 3;
    rst = 1'b1;
    wait_valid("s1_first_valid");
    chk("s1_pc0", pc, 32'h0);
    cyc(1);
    chk("s1_gap", 32'(valid), 32'd0);
    cyc(1);
    chk("s1_second_valid", 32'(valid), 32'd1);
    chk("s1_pc4", pc, 32'h4);
    wait_drain("s1_drain");

    // 2: response lands while stalled, goes to the skid buffer
    exp_req.push_back(32'hC); exp_out.push_back({32'hC, 32'hC});
    grants_left = 1;
    wait_valid("s2_c_valid");
    stall = 1'b1;
    exp_req.push_back(32'h10); exp_out.push_back({32'h10, 32'h00A0_0093});
    grants_left = 1;
    cyc(4);
    chk("s2_hold_pc",    pc, 32'hC);
    chk("s2_hold_inst",  inst, 32'hC);
    chk("s2_hold_valid", 32'(valid), 32'd1);
    chk("s2_no_req",     32'(imem.req), 32'd0);
    stall = 1'b0;
    cyc(1);
    chk("s2_pc",    pc, 32'h10);
    chk("s2_inst",  inst, 32'h00A0_0093);
    chk("s2_valid", 32'(valid), 32'd1);
    chk("s2_req",   32'(imem.req), 32'd1);
    chk("s2_addr",  imem.addr, 32'h14);
    wait_drain("s2_drain");

    // 3: branch during WAIT, stale response two cycles later
    rv_delay = 3;
    exp_req.push_back(32'h14);
    grants_left = 1;
    cyc(1);
    branch = 1'b1; target = 32'h100;
    cyc(1);
    branch = 1'b0;
    chk("s3_flush_valid", 32'(valid), 32'd0);
    chk("s3_flush_inst",  inst, NOP);
    chk("s3_pc_hold",     pc, 32'h10);
    cyc(2);
    chk("s3_stale_valid", 32'(valid), 32'd0);
    chk("s3_stale_inst",  inst, NOP);
    chk("s3_req",         32'(imem.req), 32'd1);
    chk("s3_addr",        imem.addr, 32'h100);
    rv_delay = 1;
    exp_req.push_back(32'h100); exp_out.push_back({32'h100, 32'h100});
    grants_left = 1;
    wait_valid("s3_tgt_valid");
    chk("s3_tgt_pc", pc, 32'h100);
    wait_drain("s3_drain");

    // 4a: branch in REQ without grant retargets the request
    branch = 1'b1; target = 32'h200;
    cyc(1);
    branch = 1'b0;
    chk("s4a_req",  32'(imem.req), 32'd1);
    chk("s4a_addr", imem.addr, 32'h200);
    exp_req.push_back(32'h200); exp_out.push_back({32'h200, 32'h200});
    grants_left = 1;
    wait_valid("s4a_valid");
    chk("s4a_pc", pc, 32'h200);
    wait_drain("s4a_drain");

    // 4b: branch in REQ with grant kills the old response
    exp_req.push_back(32'h204);
    grants_left = 1;
    branch = 1'b1; target = 32'h300;
    cyc(1);
    branch = 1'b0;
    cyc(1);
    chk("s4b_valid", 32'(valid), 32'd0);
    chk("s4b_req",   32'(imem.req), 32'd1);
    chk("s4b_addr",  imem.addr, 32'h300);
    exp_req.push_back(32'h300); exp_out.push_back({32'h300, 32'h300});
    grants_left = 1;
    wait_valid("s4b_tgt_valid");
    chk("s4b_tgt_pc", pc, 32'h300);
    wait_drain("s4b_drain");

    // 5: branch while stalled with the buffer full
    exp_req.push_back(32'h304); exp_req.push_back(32'h308);
    grants_left = 2;
    wait_valid("s5_first_valid");
    stall = 1'b1;
    cyc(2);
    chk("s5_hold_pc",    pc, 32'h304);
    chk("s5_hold_valid", 32'(valid), 32'd1);
    chk("s5_full_noreq", 32'(imem.req), 32'd0);
    branch = 1'b1; target = 32'h400;
    cyc(1);
    branch = 1'b0;
    chk("s5_flush_inst",  inst, NOP);
    chk("s5_flush_valid", 32'(valid), 32'd0);
    chk("s5_pc_hold",     pc, 32'h304);
    chk("s5_req",         32'(imem.req), 32'd1);
    chk("s5_addr",        imem.addr, 32'h400);
    stall = 1'b0;
    exp_req.push_back(32'h400); exp_out.push_back({32'h400, 32'h400});
    grants_left = 1;
    wait_valid("s5_tgt_valid");
    chk("s5_tgt_pc", pc, 32'h400);
    wait_drain("s5_drain");

    // 6: reset mid-WAIT, response arrives during reset
    rv_delay = 3;
    exp_req.push_back(32'h404);
    grants_left = 1;
    cyc(1);
    rst = 1'b0;
    #1;
    chk("s6_req",   32'(imem.req), 32'd0);
    chk("s6_addr",  imem.addr, 32'h0);
    chk("s6_pc",    pc, 32'h0);
    chk("s6_inst",  inst, NOP);
    chk("s6_valid", 32'(valid), 32'd0);
    cyc(4);
    rv_delay = 1;
    exp_req.push_back(32'h0); exp_out.push_back({32'h0, 32'h0});
    grants_left = 1;
    rst = 1'b1;
    cyc(2);
    chk("s6_no_spurious", 32'(valid), 32'd0);
    wait_valid("s6_valid_after");
    chk("s6_pc_after", pc, 32'h0);
    wait_drain("s6_drain");

    // 7: PC increment wraps at the top of the address space
    branch = 1'b1; target = 32'hFFFF_FFFC;
    cyc(1);
    branch = 1'b0;
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    exp_out.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC}); exp_out.push_back({32'h0, 32'h0});
    grants_left = 2;
    wait_drain("s7_wrap_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
